decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/decode_imm_gen.sv | 22 ++
 rtl/decode.sv | 201 ++++++++++++++++++++
 tb/tb_decode.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction formats, ALU operation codes
// and the default bubble instruction.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h00000013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: sign-extended immediate for the given format.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] inst_i,
    input  logic [2:0]  fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            FMT_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U: imm_o = {inst_i[31:12], 12'b0};
            FMT_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: one-deep stage register with stall, flush and load-use hazard bubble.
// Define RV32M_EN to decode the M-extension multiply/divide encodings.
module decode
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic        decode_pipeline_ctl_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_re,
    output logic        fetch_ready,
    output logic        decode_pipeline_ctl_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [4:0]  alu_op,
    output logic [2:0]  funct3,
    output logic        rd_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        illegal
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    fmt_e       fmt;
    alu_op_e    alu;
    logic       we_raw, re_raw, wr_raw, ill;
    logic       hazard;

    assign opcode = inst_q[6:0];
    assign f3     = inst_q[14:12];
    assign f7     = inst_q[31:25];

    always_comb begin
        fmt       = FMT_R;
        alu       = ALU_ADD;
        we_raw    = 1'b0;
        re_raw    = 1'b0;
        wr_raw    = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        ill       = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OP_LUI:   begin fmt = FMT_U; alu = ALU_PASSB; we_raw = 1'b1; end
                OP_AUIPC: begin fmt = FMT_U; we_raw = 1'b1; end
                OP_JAL:   begin fmt = FMT_J; we_raw = 1'b1; is_jal = 1'b1; end
                OP_JALR: begin
                    fmt = FMT_I; we_raw = 1'b1; is_jalr = 1'b1;
                    ill = (f3 != 3'd0);
                end
                OP_BRANCH: begin
                    fmt = FMT_B; alu = ALU_SUB; is_branch = 1'b1;
                    ill = (f3 == 3'd2) || (f3 == 3'd3);
                end
                OP_LOAD: begin
                    fmt = FMT_I; re_raw = 1'b1; we_raw = 1'b1;
                    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                end
                OP_STORE: begin
                    fmt = FMT_S; wr_raw = 1'b1;
                    ill = (f3 > 3'd2);
                end
                OP_IMM: begin
                    fmt = FMT_I; we_raw = 1'b1;
                    case (f3)
                        3'd0: alu = ALU_ADD;
                        3'd1: begin alu = ALU_SLL; ill = (f7 != F7_BASE); end
                        3'd2: alu = ALU_SLT;
                        3'd3: alu = ALU_SLTU;
                        3'd4: alu = ALU_XOR;
                        3'd5: begin
                            alu = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                            ill = (f7 != F7_BASE) && (f7 != F7_ALT);
                        end
                        3'd6: alu = ALU_OR;
                        default: alu = ALU_AND;
                    endcase
                end
                OP_REG: begin
                    fmt = FMT_R; we_raw = 1'b1;
                    if (f7 == F7_BASE) begin
                        case (f3)
                            3'd0: alu = ALU_ADD;
                            3'd1: alu = ALU_SLL;
                            3'd2: alu = ALU_SLT;
                            3'd3: alu = ALU_SLTU;
                            3'd4: alu = ALU_XOR;
                            3'd5: alu = ALU_SRL;
                            3'd6: alu = ALU_OR;
                            default: alu = ALU_AND;
                        endcase
                    end else if (f7 == F7_ALT) begin
                        if (f3 == 3'd0)      alu = ALU_SUB;
                        else if (f3 == 3'd5) alu = ALU_SRA;
                        else                 ill = 1'b1;
                    end else if (f7 == F7_MUL) begin
`ifdef RV32M_EN
                        case (f3)
                            3'd0: alu = ALU_MUL;
                            3'd1: alu = ALU_MULH;
                            3'd2: alu = ALU_MULHSU;
                            3'd3: alu = ALU_MULHU;
                            3'd4: alu = ALU_DIV;
                            3'd5: alu = ALU_DIVU;
                            3'd6: alu = ALU_REM;
                            default: alu = ALU_REMU;
                        endcase
`else
                        ill = 1'b1;
`endif
                    end else begin
                        ill = 1'b1;
                    end
                end
                OP_FENCE: begin
                    fmt = FMT_I;
                    ill = (f3 > 3'd1);
                end
                OP_SYSTEM: begin
                    // Only ECALL/EBREAK are accepted; CSR access is outside the base set.
                    fmt = FMT_I;
                    ill = (inst_q != 32'h00000073) && (inst_q != 32'h00100073);
                end
                default: ill = 1'b1;
            endcase
        end
    end

    imm_gen u_imm_gen (
        .inst_i (inst_q[31:7]),
        .fmt_i  (fmt),
        .imm_o  (imm)
    );

    assign rs1     = inst_q[19:15];
    assign rs2     = inst_q[24:20];
    assign rd      = inst_q[11:7];
    assign funct3  = f3;
    assign alu_op  = alu;
    assign pc_out  = pc_q;
    assign illegal = ill;
    assign rd_we   = we_raw & ~ill & (rd != 5'd0);
    assign mem_re  = re_raw & ~ill;
    assign mem_we  = wr_raw & ~ill;

    // Load-use check only looks at the source fields the held format actually reads.
    assign hazard = valid_q & ex_mem_re & (ex_rd != 5'd0) &
                    ((((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B)) && (ex_rd == rs1)) ||
                     (((fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B)) && (ex_rd == rs2)));

    assign fetch_ready             = ~(stall | hazard);
    assign decode_pipeline_ctl_out = valid_q & ~hazard;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (fetch_ready) begin
            inst_d  = inst;
            pc_d    = pc;
            valid_d = decode_pipeline_ctl_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        decode_pipeline_ctl_in;
    logic        stall;
    logic        flush;
    logic [4:0]  ex_rd;
    logic        ex_mem_re;
    logic        fetch_ready;
    logic        decode_pipeline_ctl_out;
    logic [31:0] pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [2:0]  funct3;
    logic        rd_we, mem_re, mem_we, is_branch, is_jal, is_jalr, illegal;

    int unsigned checks = 0;
    int unsigned failures = 0;

    decode #(.NOP_INST(32'h00000013)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .inst                    (inst),
        .pc                      (pc),
        .decode_pipeline_ctl_in  (decode_pipeline_ctl_in),
        .stall                   (stall),
        .flush                   (flush),
        .ex_rd                   (ex_rd),
        .ex_mem_re               (ex_mem_re),
        .fetch_ready             (fetch_ready),
        .decode_pipeline_ctl_out (decode_pipeline_ctl_out),
        .pc_out                  (pc_out),
        .rs1                     (rs1),
        .rs2                     (rs2),
        .rd                      (rd),
        .imm                     (imm),
        .alu_op                  (alu_op),
        .funct3                  (funct3),
        .rd_we                   (rd_we),
        .mem_re                  (mem_re),
        .mem_we                  (mem_we),
        .is_branch               (is_branch),
        .is_jal                  (is_jal),
        .is_jalr                 (is_jalr),
        .illegal                 (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] p);
        inst = i;
        pc = p;
        decode_pipeline_ctl_in = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        inst = '0;
        pc = '0;
        decode_pipeline_ctl_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ex_rd = '0;
        ex_mem_re = 1'b0;
        repeat (2) step();

        check("rst_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        rst_n = 1'b1;

        // addi x1,x2,5
        present(32'h00510093, 32'h100);
        step();
        check("addi_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_rs1", 32'(rs1), 32'd2);
        check("addi_imm", imm, 32'd5);
        check("addi_alu_op", 32'(alu_op), 32'(ALU_ADD));
        check("addi_rd_we", 32'(rd_we), 32'd1);
        check("addi_pc_out", pc_out, 32'h100);

        // beq x0,x0,-4
        present(32'hFE000EE3, 32'h104);
        step();
        check("beq_is_branch", 32'(is_branch), 32'd1);
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_rd_we", 32'(rd_we), 32'd0);

        // stall for three cycles with a new instruction presented
        stall = 1'b1;
        present(32'h00510093, 32'h200);
        #1;
        check("stall_fetch_ready", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc_out", pc_out, 32'h104);
            check("stall_imm", imm, 32'hFFFFFFFC);
            check("stall_is_branch", 32'(is_branch), 32'd1);
            check("stall_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
            check("stall_fetch_ready", 32'(fetch_ready), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("release_fetch_ready", 32'(fetch_ready), 32'd1);
        step();
        check("release_pc_out", pc_out, 32'h200);
        check("release_rd", 32'(rd), 32'd1);
        check("release_is_branch", 32'(is_branch), 32'd0);

        // flush beats stall
        stall = 1'b1;
        flush = 1'b1;
        present(32'h00812183, 32'h204);
        step();
        check("flush_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        check("flush_rd_we", 32'(rd_we), 32'd0);
        check("flush_mem_re", 32'(mem_re), 32'd0);
        check("flush_illegal", 32'(illegal), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // add x6,x5,x1 with load-use hazards on rs1 and rs2
        present(32'h00128333, 32'h240);
        step();
        check("add_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("add_rd", 32'(rd), 32'd6);
        ex_mem_re = 1'b1;
        ex_rd = 5'd5;
        present(32'h00510093, 32'h300);
        #1;
        check("haz_rs1_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        check("haz_rs1_fetch_ready", 32'(fetch_ready), 32'd0);
        step();
        check("haz_hold_pc_out", pc_out, 32'h240);
        ex_mem_re = 1'b0;
        #1;
        check("haz_clear_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("haz_clear_fetch_ready", 32'(fetch_ready), 32'd1);
        ex_mem_re = 1'b1;
        ex_rd = 5'd1;
        #1;
        check("haz_rs2_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        ex_rd = 5'd7;
        #1;
        check("haz_nomatch_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        ex_rd = 5'd0;
        #1;
        check("haz_x0_fetch_ready", 32'(fetch_ready), 32'd1);
        ex_mem_re = 1'b0;
        step();
        check("haz_next_pc_out", pc_out, 32'h300);

        // M-extension encoding: mul x0,x1,x2
        present(32'h02208033, 32'h304);
        step();
`ifdef RV32M_EN
        check("mul_illegal", 32'(illegal), 32'd0);
        check("mul_alu_op", 32'(alu_op), 32'(ALU_MUL));
`else
        check("mul_illegal", 32'(illegal), 32'd1);
`endif
        check("mul_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("mul_rd_we", 32'(rd_we), 32'd0);

        present(32'h00000000, 32'h308);
        step();
        check("zero_illegal", 32'(illegal), 32'd1);
        check("zero_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("zero_rd_we", 32'(rd_we), 32'd0);

        // lw x3,8(x2)
        present(32'h00812183, 32'h30C);
        step();
        check("lw_mem_re", 32'(mem_re), 32'd1);
        check("lw_rd_we", 32'(rd_we), 32'd1);
        check("lw_imm", imm, 32'd8);

        // sw x5,-4(x2)
        present(32'hFE512E23, 32'h310);
        step();
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_rd_we", 32'(rd_we), 32'd0);
        check("sw_imm", imm, 32'hFFFFFFFC);
        check("sw_funct3", 32'(funct3), 32'd2);

        // lui x7,0x12345
        present(32'h123453B7, 32'h314);
        step();
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu_op", 32'(alu_op), 32'(ALU_PASSB));
        check("lui_rd_we", 32'(rd_we), 32'd1);

        // jal x1,+8
        present(32'h008000EF, 32'h318);
        step();
        check("jal_is_jal", 32'(is_jal), 32'd1);
        check("jal_imm", imm, 32'd8);
        check("jal_rd_we", 32'(rd_we), 32'd1);

        present(32'h00000073, 32'h31C);
        step();
        check("ecall_illegal", 32'(illegal), 32'd0);
        check("ecall_rd_we", 32'(rd_we), 32'd0);

        // reset in the middle of a stall abandons the held instruction
        present(32'h00510093, 32'h400);
        step();
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_stall_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        check("rst_stall_rd_we", 32'(rd_we), 32'd0);
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        decode_pipeline_ctl_in = 1'b0;
        step();
        check("post_rst_idle_ctl_out", 32'(decode_pipeline_ctl_out), 32'd0);
        present(32'h00510093, 32'h500);
        step();
        check("post_rst_accept_ctl_out", 32'(decode_pipeline_ctl_out), 32'd1);
        check("post_rst_accept_pc_out", pc_out, 32'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
